div_unit: RTL and testbench

Iterative 32-bit integer divider serving MIPS DIV/DIVU beside the single-cycle ALU in the execute stage. It accepts one signed or unsigned divide through a valid/ready handshake and runs a radix-2 restoring algorithm on operand magnitudes, one quotient bit per cycle. It then applies sign correction and presents quotient and remainder for the HI/LO write, holding them until the next accepted operation. The pipeline stalls on `div_busy` and kills in-flight work with `div_cancel` on exception or flush.

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_step.sv | 24 ++
 rtl/div_unit.sv | 104 ++++++++++
 tb/tb_div_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: default width, FSM encodings
// and iteration-counter width.
package div_defs;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CNT_W      = $clog2(DIV_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep the difference when it is non-negative.
module div_step
  import div_defs::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] prem,
  input  logic                  dvd_bit,
  input  logic [DATA_WIDTH-1:0] dvs,
  output logic [DATA_WIDTH-1:0] prem_nxt,
  output logic                  q_bit
);

  logic        [DATA_WIDTH:0] shifted;
  logic signed [DATA_WIDTH:0] diff;

  // prem < dvs holds between iterations, so DATA_WIDTH+1 bits never overflow
  assign shifted  = {prem, dvd_bit};
  assign diff     = $signed(shifted - {1'b0, dvs});
  assign q_bit    = (diff >= 0);
  assign prem_nxt = q_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: restoring division on magnitudes, one
// quotient bit per cycle, sign fix-up in a final cycle, results held for HI/LO.
module div_unit
  import div_defs::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_valid,
  input  logic                  div_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  div_cancel,
  output logic                  div_ready,
  output logic                  div_busy,
  output logic                  div_done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ONE      = 1;
  localparam logic [CNT_W-1:0]      LAST_IT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = 1;

  div_state_e state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] prem, qsh, dvs_mag, dvd_raw;
  logic                  q_neg, r_neg, dvs_zero;
  logic                  accept, last_iter;
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_q;

  function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v,
                                                   input logic                  c);
    return c ? (~v + ONE) : v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v,
                                                input logic                  is_signed);
    return neg_if(v, is_signed & v[DATA_WIDTH-1]);
  endfunction

  assign div_ready = (state == IDLE) || (state == DONE);
  assign div_busy  = (state == CALC) || (state == FIX);
  assign div_done  = (state == DONE);
  assign accept    = div_valid & div_ready & ~div_cancel;
  assign last_iter = (cnt == LAST_IT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (div_cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nxt;
      if (accept) cnt <= '0;
      else if (state == CALC) cnt <= cnt + CNT_ONE;
      if (state == FIX && !div_cancel) begin
        quotient  <= dvs_zero ? '1 : neg_if(qsh, q_neg);
        remainder <= dvs_zero ? dvd_raw : neg_if(prem, r_neg);
      end
    end
  end

  // Operand latch and iteration datapath; qsh shifts dividend bits out and quotient bits in
  always_ff @(posedge clk) begin
    if (accept) begin
      prem     <= '0;
      qsh      <= mag(dividend, div_signed);
      dvs_mag  <= mag(divisor, div_signed);
      dvd_raw  <= dividend;
      q_neg    <= div_signed & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
      r_neg    <= div_signed & dividend[DATA_WIDTH-1];
      dvs_zero <= (divisor == '0);
    end else if (state == CALC) begin
      prem <= step_rem;
      qsh  <= {qsh[DATA_WIDTH-2:0], step_q};
    end
  end

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .prem     (prem),
    .dvd_bit  (qsh[DATA_WIDTH-1]),
    .dvs      (dvs_mag),
    .prem_nxt (step_rem),
    .q_bit    (step_q)
  );

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by zero,
// cancel, back-to-back issue and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid, div_signed, div_cancel;
  logic [31:0] dividend, divisor;
  logic        div_ready, div_busy, div_done;
  logic [31:0] quotient, remainder;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_q = 32'h0;
  logic [31:0] last_r = 32'h0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .div_valid  (div_valid),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_cancel (div_cancel),
    .div_ready  (div_ready),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (div_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", div_ready); else n_pass++;
    n_chk++; if (div_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", div_busy); else n_pass++;
    n_chk++; if (div_done !== 1'b0) $display("FAIL reset_done: got %b want 0", div_done); else n_pass++;
    n_chk++; if (quotient !== 32'h0) $display("FAIL reset_quot: got %h want 0", quotient); else n_pass++;
    n_chk++; if (remainder !== 32'h0) $display("FAIL reset_rem: got %h want 0", remainder); else n_pass++;
    rst = 1'b0;
  endtask

  // Issues one request in cycle 0, scrambles inputs afterwards, checks busy window,
  // single done pulse in cycle 34 and the results.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er);
    int done_cyc, done_cnt;
    bit busy_bad;
    done_cyc = -1; done_cnt = 0; busy_bad = 0;
    @(negedge clk);
    div_valid = 1'b1; div_signed = s; dividend = a; divisor = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        div_valid = 1'b0; div_signed = ~s; dividend = ~a; divisor = b + 32'd3;
      end
      if (div_busy !== (k <= 33)) busy_bad = 1;
      if (div_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == 34) begin
        n_chk++; if (quotient !== eq) $display("FAIL %s_quot: got %h want %h", name, quotient, eq); else n_pass++;
        n_chk++; if (remainder !== er) $display("FAIL %s_rem: got %h want %h", name, remainder, er); else n_pass++;
      end
    end
    n_chk++; if (busy_bad) $display("FAIL %s_busy: busy window wrong, want cycles 1..33", name); else n_pass++;
    n_chk++; if (done_cyc != 34 || done_cnt != 1) $display("FAIL %s_done: first at %0d count %0d want 34/1", name, done_cyc, done_cnt); else n_pass++;
    last_q = eq; last_r = er;
  endtask

  task automatic test_results();
    run_op("u100_7",  32'd100,       32'd7,         1'b0, 32'd14,        32'd2);
    run_op("s_m7_2",  32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("u_max_1", 32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0);
    run_op("s_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_op("u_div0",  32'h1234_5678, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("s_div0",  32'h1234_5678, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
  endtask

  task automatic test_cancel();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    div_valid = 1'b1; div_cancel = 1'b1; div_signed = 1'b0; dividend = 32'd77; divisor = 32'd7;
    @(negedge clk);
    div_valid = 1'b0; div_cancel = 1'b0;
    n_chk++; if (div_busy !== 1'b0) $display("FAIL cancel_blocks_accept: busy %b want 0", div_busy); else n_pass++;
    div_valid = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) div_valid = 1'b0;
      if (div_done === 1'b1) done_cnt++;
      if (k == 10) div_cancel = 1'b1;
      if (k == 11) begin
        div_cancel = 1'b0;
        n_chk++; if (div_ready !== 1'b1) $display("FAIL cancel_ready: got %b want 1", div_ready); else n_pass++;
        n_chk++; if (div_busy !== 1'b0) $display("FAIL cancel_busy: got %b want 0", div_busy); else n_pass++;
      end
    end
    n_chk++; if (done_cnt != 0) $display("FAIL cancel_no_done: %0d pulses want 0", done_cnt); else n_pass++;
    n_chk++; if (quotient !== last_q) $display("FAIL cancel_quot_kept: got %h want %h", quotient, last_q); else n_pass++;
    n_chk++; if (remainder !== last_r) $display("FAIL cancel_rem_kept: got %h want %h", remainder, last_r); else n_pass++;
    run_op("after_cancel_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
  endtask

  task automatic test_back_to_back();
    bit busy_bad, hold_bad, done_bad;
    busy_bad = 0; hold_bad = 0; done_bad = 0;
    @(negedge clk);
    div_valid = 1'b1; div_signed = 1'b0; dividend = 32'd47; divisor = 32'd6;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      if (k == 1) begin dividend = 32'd50; divisor = 32'd5; end
      if (k == 35) div_valid = 1'b0;
      if (div_busy !== ((k <= 33) || (k >= 35 && k <= 67))) busy_bad = 1;
      if (div_done !== (k == 34 || k == 68)) done_bad = 1;
      if (k >= 34 && k <= 67 && (quotient !== 32'd7 || remainder !== 32'd5)) hold_bad = 1;
      if (k == 68) begin
        n_chk++; if (quotient !== 32'd10) $display("FAIL b2b_quot: got %h want %h", quotient, 32'd10); else n_pass++;
        n_chk++; if (remainder !== 32'd0) $display("FAIL b2b_rem: got %h want 0", remainder); else n_pass++;
      end
    end
    n_chk++; if (busy_bad) $display("FAIL b2b_busy: busy window wrong"); else n_pass++;
    n_chk++; if (done_bad) $display("FAIL b2b_done: done not exactly at 34 and 68"); else n_pass++;
    n_chk++; if (hold_bad) $display("FAIL b2b_hold: first result 7/5 not held until second FIX"); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    div_valid = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 1) div_valid = 1'b0;
      if (k == 20) rst = 1'b1;
      if (k == 21) begin
        rst = 1'b0;
        n_chk++; if (quotient !== 32'h0) $display("FAIL rstmid_quot: got %h want 0", quotient); else n_pass++;
        n_chk++; if (remainder !== 32'h0) $display("FAIL rstmid_rem: got %h want 0", remainder); else n_pass++;
        n_chk++; if (div_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", div_busy); else n_pass++;
        n_chk++; if (div_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", div_ready); else n_pass++;
      end
      if (k >= 21 && div_done === 1'b1) done_cnt++;
    end
    n_chk++; if (done_cnt != 0) $display("FAIL rstmid_no_done: %0d pulses want 0", done_cnt); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; div_valid = 1'b0; div_signed = 1'b0; div_cancel = 1'b0;
    dividend = 32'h0; divisor = 32'h0;
    test_reset();
    test_results();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
